// File: rtl/ssp_slave_rx.sv
// SSP slave receiver: oversamples the ARM-driven SPI pins on pck0, deserialises MSB-first
// words, and decodes configuration commands into the major-mode control bits.
module ssp_slave_rx #(
    parameter int WORD_W           = 16,
    parameter bit FRAME_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES      = 2,
    parameter int TIMEOUT          = 255
) (
    input  logic              pck0,
    input  logic              rst,
    input  logic              ssp_clk,
    input  logic              ssp_dout,
    input  logic              ssp_frame,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    output logic              rx_err,
    output logic [2:0]        major_mode,
    output logic              xcorr_is_848,
    output logic              snoop,
    output logic              xcorr_quarter_freq
);
    localparam int CW = $clog2(WORD_W);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, dout_sync_q, frame_sync_q;
    logic              clk_prev_q;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] rx_word_q;
    logic              rx_valid_q;
    logic [2:0]        mode_q;
    logic              is848_q, snoop_q, quarter_q;

    logic clk_s, dout_s, frame_s, clk_rise, win, tmo_hit, last_bit;

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign dout_s   = dout_sync_q[SYNC_STAGES-1];
    assign frame_s  = frame_sync_q[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev_q;
    assign win      = FRAME_ACTIVE_LOW ? ~frame_s : frame_s;
    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign last_bit = (bit_cnt_q == CW'(WORD_W - 1));

    always_ff @(posedge pck0) begin
        if (rst) begin
            state_q      <= WAIT_IDLE;
            clk_sync_q   <= '0;
            dout_sync_q  <= '0;
            frame_sync_q <= '0;
            clk_prev_q   <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rx_word_q    <= '0;
            rx_valid_q   <= 1'b0;
            mode_q       <= '0;
            is848_q      <= 1'b0;
            snoop_q      <= 1'b0;
            quarter_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ssp_clk};
            dout_sync_q  <= {dout_sync_q[SYNC_STAGES-2:0], ssp_dout};
            frame_sync_q <= {frame_sync_q[SYNC_STAGES-2:0], ssp_frame};
            clk_prev_q   <= clk_s;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rx_valid_q   <= done_q;
            if (done_q)
                rx_word_q <= shreg_q;
            // Decode sees the word in the same cycle rx_valid is high.
            if (rx_valid_q && rx_word_q[WORD_W-1 -: 4] == 4'h1) begin
                mode_q    <= rx_word_q[7:5];
                quarter_q <= rx_word_q[2];
                snoop_q   <= rx_word_q[1];
                is848_q   <= rx_word_q[0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (!win) state_d = IDLE;
            IDLE:      if (win)  state_d = SHIFT;
            SHIFT: begin
                if (!win)
                    state_d = IDLE;
                else if (!clk_rise && tmo_hit && bit_cnt_q != '0)
                    state_d = WAIT_IDLE;
            end
            default:   state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tmo_d     = '0;
            end
            SHIFT: begin
                // Window end takes priority over a coincident clock edge.
                if (!win) begin
                    err_d = (bit_cnt_q != '0);
                end else if (clk_rise) begin
                    shreg_d   = {shreg_q[WORD_W-2:0], dout_s};
                    tmo_d     = '0;
                    done_d    = last_bit;
                    bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
                end else begin
                    if (tmo_q != TW'(TIMEOUT))
                        tmo_d = tmo_q + TW'(1);
                    err_d = tmo_hit && (bit_cnt_q != '0);
                end
            end
            default: ;
        endcase
    end

    assign rx_word            = rx_word_q;
    assign rx_valid           = rx_valid_q;
    assign rx_err             = err_q;
    assign major_mode         = mode_q;
    assign xcorr_is_848       = is848_q;
    assign snoop              = snoop_q;
    assign xcorr_quarter_freq = quarter_q;
endmodule

// File: tb/tb_ssp_slave_rx.sv
// Scoreboard bench for ssp_slave_rx: words queued as the SPI master drives them,
// popped and compared when rx_valid fires; error pulses and config decode tracked alongside.
module tb_ssp_slave_rx;
    localparam int TMO = 255;

    logic        pck0 = 1'b0, rst = 1'b1;
    logic        ssp_clk = 1'b0, ssp_dout = 1'b0, ssp_frame = 1'b1;
    logic [15:0] rx_word;
    logic        rx_valid, rx_err;
    logic [2:0]  major_mode;
    logic        xcorr_is_848, snoop, xcorr_quarter_freq;

    ssp_slave_rx dut (
        .pck0(pck0), .rst(rst), .ssp_clk(ssp_clk), .ssp_dout(ssp_dout), .ssp_frame(ssp_frame),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_err(rx_err), .major_mode(major_mode),
        .xcorr_is_848(xcorr_is_848), .snoop(snoop), .xcorr_quarter_freq(xcorr_quarter_freq)
    );

    always #5 pck0 = ~pck0;

    int cyc = 0;
    always @(posedge pck0) cyc++;

    int n_cmp = 0, n_bad = 0;
    int n_vld = 0, n_err = 0, vld_cyc = 0, err_cyc = 0, rise_cyc = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge pck0) begin
        if (rx_valid || rx_err)
            check("vld_err_excl", 32'(rx_valid & rx_err), 0);
        if (rx_valid) begin
            n_vld++;
            vld_cyc = cyc;
            check("valid_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
                check("rx_word", 32'(rx_word), 32'(exp_q.pop_front()));
        end
        if (rx_err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic bit_out(input logic b, input int half);
        ssp_dout = b;
        #(half);
        ssp_clk  = 1'b1;
        rise_cyc = cyc;
        #(half);
        ssp_clk  = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input int half);
        for (int i = 0; i < n; i++) bit_out(w[15-i], half);
    endtask

    task automatic send_word(input logic [15:0] w, input int half);
        exp_q.push_back(w);
        send_bits(w, 16, half);
    endtask

    task automatic frame_on();
        ssp_frame = 1'b0;
        #40;
    endtask

    task automatic frame_off();
        ssp_frame = 1'b1;
        #80;
    endtask

    task automatic wait_vld(input int target);
        int k = 0;
        #1;
        while (n_vld < target && k < 60) begin
            @(negedge pck0);
            #1;
            k++;
        end
        check("vld_arrived", n_vld, target);
    endtask

    task automatic check_cfg(input string tag, input logic [2:0] m, input logic q, input logic s, input logic i);
        check(tag, {major_mode, xcorr_quarter_freq, snoop, xcorr_is_848}, {m, q, s, i});
    endtask

    initial begin
        int v0, e0, k;
        repeat (3) @(negedge pck0);
        #1;
        check("rst_word", 32'(rx_word), 0);
        check("rst_flags", {rx_valid, rx_err, major_mode, xcorr_is_848, snoop, xcorr_quarter_freq}, 0);
        rst = 1'b0;
        repeat (4) @(negedge pck0);

        // Single config word at pck0/8 with latency measurement
        frame_on();
        send_word(16'h10A7, 40);
        wait_vld(1);
        check("latency", vld_cyc - rise_cyc, 4);
        check_cfg("cfg_before_update", 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge pck0); #1;
        check_cfg("cfg_10A7", 3'b101, 1'b1, 1'b1, 1'b1);
        frame_off();
        check("no_err_1", n_err, 0);

        // Two words in one frame; only the second is a config command
        frame_on();
        send_word(16'h2003, 40);
        wait_vld(2);
        repeat (3) @(negedge pck0);
        check_cfg("cfg_after_2003", 3'b101, 1'b1, 1'b1, 1'b1);
        send_word(16'h1001, 40);
        wait_vld(3);
        @(negedge pck0); #1;
        check_cfg("cfg_1001", 3'b000, 1'b0, 1'b0, 1'b1);
        frame_off();

        // Early frame end after 9 clocks
        v0 = n_vld; e0 = n_err;
        frame_on();
        send_bits(16'hFFFF, 9, 40);
        frame_off();
        repeat (5) @(negedge pck0); #1;
        check("early_end_err", n_err - e0, 1);
        check("early_end_novld", n_vld - v0, 0);
        check_cfg("cfg_after_err", 3'b000, 1'b0, 1'b0, 1'b1);
        frame_on();
        send_word(16'h1020, 40);
        wait_vld(v0 + 1);
        @(negedge pck0); #1;
        check_cfg("cfg_1020", 3'b001, 1'b0, 1'b0, 1'b0);
        frame_off();

        // Clock stalls inside an active frame
        v0 = n_vld; e0 = n_err;
        frame_on();
        send_bits(16'hA5A5, 5, 40);
        repeat (300) @(negedge pck0); #1;
        check("tmo_err", n_err - e0, 1);
        check("tmo_window", 32'((err_cyc - rise_cyc) >= TMO && (err_cyc - rise_cyc) <= TMO + 6), 1);
        check("tmo_novld", n_vld - v0, 0);
        frame_off();
        frame_on();
        send_word(16'h3055, 40);
        wait_vld(v0 + 1);
        @(negedge pck0); #1;
        check_cfg("cfg_after_3055", 3'b001, 1'b0, 1'b0, 1'b0);
        frame_off();

        // Reset in the middle of a word
        v0 = n_vld; e0 = n_err;
        frame_on();
        send_bits(16'h10FF, 8, 40);
        @(negedge pck0);
        rst = 1'b1;
        @(negedge pck0);
        rst = 1'b0;
        #1;
        check("midrst_word", 32'(rx_word), 0);
        check("midrst_flags", {rx_valid, rx_err, major_mode, xcorr_is_848, snoop, xcorr_quarter_freq}, 0);
        send_bits(16'hFF00, 8, 40);
        frame_off();
        repeat (6) @(negedge pck0); #1;
        check("midrst_novld", n_vld - v0, 0);
        check("midrst_noerr", n_err - e0, 0);
        frame_on();
        send_word(16'h10E2, 40);
        wait_vld(v0 + 1);
        @(negedge pck0); #1;
        check_cfg("cfg_10E2", 3'b111, 1'b0, 1'b1, 1'b0);
        frame_off();

        // pck0/4 sweep with random phase, back-to-back words per frame
        v0 = n_vld;
        for (int f = 0; f < 100; f++) begin
            #($urandom_range(0, 9));
            frame_on();
            for (int w = 0; w < 10; w++) send_word(16'($urandom), 20);
            frame_off();
        end
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge pck0); #1;
            k++;
        end
        check("sweep_drain", exp_q.size(), 0);
        check("sweep_count", n_vld - v0, 1000);
        check("total_err", n_err, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
